mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/lc3b_mem_pkg.sv | 62 ++++++
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_pkg.sv
// Shared types, encodings and bounds for the LC-3b memory controller.
// Holds the state enum, the access encodings, the request payload and the byte-lane helpers.
package lc3b_mem_pkg;

    localparam int unsigned LATENCY_MIN = 3;
    localparam int unsigned LATENCY_MAX = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned SRAM_AW     = 15;
    localparam int unsigned WE_W        = 2;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        READY  = 2'd3
    } mem_state_e;

    typedef enum logic {
        DATA_WORD = 1'b0,
        DATA_BYTE = 1'b1
    } data_size_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rw_e;

    typedef struct packed {
        rw_e                 rw;
        data_size_e          size;
        logic [ADDR_W-1:0]   mar;
        logic [DATA_W-1:0]   mdr;
    } mem_req_t;

    // Byte-lane enables: bit 1 = high byte (odd address), bit 0 = low byte.
    function automatic logic [WE_W-1:0] byte_we(input mem_req_t req);
        logic [WE_W-1:0] we;
        we = '0;
        if (req.rw == WRITE) begin
            if (req.size == DATA_WORD) begin
                we = 2'b11;
            end else begin
                we = req.mar[0] ? 2'b10 : 2'b01;
            end
        end
        return we;
    endfunction

    // Byte writes replicate the low MDR byte onto both lanes; the enables pick the lane.
    function automatic logic [DATA_W-1:0] write_data(input mem_req_t req);
        logic [DATA_W-1:0] wd;
        if (req.size == DATA_BYTE) begin
            wd = {req.mdr[7:0], req.mdr[7:0]};
        end else begin
            wd = req.mdr;
        end
        return wd;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// WAIT-state countdown: loadable down-counter with a terminal flag.
// zero_c marks the cycle whose decrement brings the count to zero.
module mem_wait_counter
    import lc3b_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count <= CNT_W'(1));

endmodule

// File: rtl/mem_ctrl.sv
// LC-3b memory controller: captures a control-store request, waits out the configured
// latency, performs one synchronous SRAM access and strobes R when the access completes.
module mem_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MIO_EN,
    input  logic               R_W,
    input  logic               DATA_SIZE,
    input  logic [ADDR_W-1:0]  MAR,
    input  logic [DATA_W-1:0]  MDR,
    output logic               R,
    output logic [DATA_W-1:0]  databus_out,
    output logic               sram_en,
    output logic [WE_W-1:0]    sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - LATENCY_MIN);

    mem_state_e        state;
    mem_state_e        state_next;
    mem_req_t          req_q;
    mem_req_t          req_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero_c;

    logic              r_d;
    logic              sram_en_d;
    logic [WE_W-1:0]   sram_we_d;
    logic [DATA_W-1:0] sram_wdata_d;
    logic              rd_ready_q;
    logic              rd_ready_d;
    logic [DATA_W-1:0] rd_hold_q;

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // State register and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            state <= state_next;
            req_q <= req_d;
        end
    end

    // Next state, counter control and request capture.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        req_d      = req_q;
        unique case (state)
            IDLE: begin
                if (MIO_EN) begin
                    req_d      = '{rw:   rw_e'(R_W),
                                   size: data_size_e'(DATA_SIZE),
                                   mar:  MAR,
                                   mdr:  MDR};
                    cnt_load   = 1'b1;
                    state_next = (LATENCY == LATENCY_MIN) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero_c) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = READY;
            READY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        r_d          = 1'b0;
        sram_en_d    = 1'b0;
        sram_we_d    = '0;
        sram_wdata_d = sram_wdata;
        rd_ready_d   = 1'b0;
        unique case (state_next)
            ACCESS: begin
                sram_en_d    = 1'b1;
                sram_we_d    = byte_we(req_d);
                sram_wdata_d = write_data(req_d);
            end
            READY: begin
                r_d        = 1'b1;
                rd_ready_d = (req_d.rw == READ);
            end
            default: ;
        endcase
    end

    // Output registers; the read word is captured as READY ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R          <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= '0;
            sram_wdata <= '0;
            rd_ready_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            R          <= r_d;
            sram_en    <= sram_en_d;
            sram_we    <= sram_we_d;
            sram_wdata <= sram_wdata_d;
            rd_ready_q <= rd_ready_d;
            if (rd_ready_q) begin
                rd_hold_q <= sram_rdata;
            end
        end
    end

    // SRAM read data flows straight through during a read's READY cycle.
    assign databus_out = rd_ready_q ? sram_rdata : rd_hold_q;
    assign sram_addr   = req_q.mar[ADDR_W-1:1];

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: LATENCY=5 and LATENCY=3 instances share stimulus, each with its own
// SRAM, checked cycle by cycle against a transaction-level model of the access timing.
module tb_mem_ctrl;
    import lc3b_mem_pkg::*;

    localparam int unsigned NDUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio_en;
    logic        r_w;
    logic        data_size;
    logic [15:0] mar;
    logic [15:0] mdr;

    logic        r_o     [NDUT];
    logic [15:0] dbo_o   [NDUT];
    logic        en_o    [NDUT];
    logic [1:0]  we_o    [NDUT];
    logic [14:0] addr_o  [NDUT];
    logic [15:0] wdata_o [NDUT];
    logic [15:0] rdata_o [NDUT];

    logic [15:0] sram    [NDUT][32768];
    logic [15:0] ref_mem [NDUT][32768];
    logic [15:0] held    [NDUT];
    logic [14:0] prev_addr [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.LATENCY(5)) u_dut5 (
        .clk(clk), .rst(rst), .MIO_EN(mio_en), .R_W(r_w), .DATA_SIZE(data_size),
        .MAR(mar), .MDR(mdr), .R(r_o[0]), .databus_out(dbo_o[0]),
        .sram_en(en_o[0]), .sram_we(we_o[0]), .sram_addr(addr_o[0]),
        .sram_wdata(wdata_o[0]), .sram_rdata(rdata_o[0])
    );

    mem_ctrl #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .MIO_EN(mio_en), .R_W(r_w), .DATA_SIZE(data_size),
        .MAR(mar), .MDR(mdr), .R(r_o[1]), .databus_out(dbo_o[1]),
        .sram_en(en_o[1]), .sram_we(we_o[1]), .sram_addr(addr_o[1]),
        .sram_wdata(wdata_o[1]), .sram_rdata(rdata_o[1])
    );

    // Synchronous SRAMs: read data appears the cycle after sram_en.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (en_o[d]) begin
                rdata_o[d] <= sram[d][addr_o[d]];
                if (we_o[d][1]) sram[d][addr_o[d]][15:8] <= wdata_o[d][15:8];
                if (we_o[d][0]) sram[d][addr_o[d]][7:0]  <= wdata_o[d][7:0];
            end
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 5 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One access: request in cycle 1, inputs scrambled from cycle 2, optional reset in rst_cycle.
    task automatic run_txn(input logic rw, input logic size, input logic [15:0] a,
                           input logic [15:0] wd_in, input int rst_cycle,
                           input logic [15:0] late_mar);
        logic [14:0] wa;
        logic [1:0]  exp_we;
        logic [15:0] exp_wd;
        logic [15:0] rd_exp [NDUT];
        wa     = a[15:1];
        exp_we = !rw ? 2'b00 : (!size ? 2'b11 : (a[0] ? 2'b10 : 2'b01));
        exp_wd = size ? {wd_in[7:0], wd_in[7:0]} : wd_in;
        for (int d = 0; d < NDUT; d++) rd_exp[d] = ref_mem[d][wa];

        mio_en = 1'b1; r_w = rw; data_size = size; mar = a; mdr = wd_in;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                int lat;
                bit alive;
                bit exp_en;
                logic [14:0] exp_addr;
                logic [15:0] exp_dbo;
                lat    = lat_of(d);
                alive  = (rst_cycle == 0) || (c < rst_cycle);
                exp_en = alive && (c == lat - 1);
                exp_addr = (c == 1) ? prev_addr[d] : (alive ? wa : 15'h0);
                if (!alive)                exp_dbo = 16'h0;
                else if (!rw && c >= lat)  exp_dbo = rd_exp[d];
                else                       exp_dbo = held[d];
                check($sformatf("L%0d c%0d sram_en", lat, c), en_o[d], exp_en);
                check($sformatf("L%0d c%0d R", lat, c), r_o[d], alive && (c == lat));
                check($sformatf("L%0d c%0d sram_we", lat, c), we_o[d], exp_en ? exp_we : 2'b00);
                check($sformatf("L%0d c%0d sram_addr", lat, c), addr_o[d], exp_addr);
                check($sformatf("L%0d c%0d databus_out", lat, c), dbo_o[d], exp_dbo);
                if (exp_en && rw)
                    check($sformatf("L%0d c%0d sram_wdata", lat, c), wdata_o[d], exp_wd);
            end
            @(posedge clk); #1;
            if (c == 1) begin
                mio_en = 1'b0; r_w = 1'($urandom); data_size = 1'($urandom);
                mar = late_mar; mdr = 16'($urandom);
            end
            if (c + 1 == rst_cycle) rst = 1'b1;
            if (rst_cycle != 0 && c == rst_cycle) rst = 1'b0;
        end

        for (int d = 0; d < NDUT; d++) begin
            if (rw && (rst_cycle == 0 || lat_of(d) - 1 < rst_cycle)) begin
                if (exp_we[1]) ref_mem[d][wa][15:8] = exp_wd[15:8];
                if (exp_we[0]) ref_mem[d][wa][7:0]  = exp_wd[7:0];
            end
            if (rst_cycle != 0) held[d] = 16'h0;
            else if (!rw)       held[d] = rd_exp[d];
            prev_addr[d] = (rst_cycle != 0) ? 15'h0 : wa;
            check($sformatf("L%0d sram[%0h] contents", lat_of(d), wa), sram[d][wa], ref_mem[d][wa]);
        end
    endtask

    initial begin
        rst = 1'b1; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0; mar = '0; mdr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("L%0d reset R", lat_of(d)), r_o[d], 1'b0);
            check($sformatf("L%0d reset sram_en", lat_of(d)), en_o[d], 1'b0);
            check($sformatf("L%0d reset sram_we", lat_of(d)), we_o[d], 2'b00);
            check($sformatf("L%0d reset sram_addr", lat_of(d)), addr_o[d], 15'h0);
            check($sformatf("L%0d reset databus_out", lat_of(d)), dbo_o[d], 16'h0);
            held[d] = 16'h0;
            prev_addr[d] = 15'h0;
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Word write then word read of 0xBEEF, with MAR moved to 0x4000 after capture.
        run_txn(1'b1, 1'b0, 16'h0020, 16'hBEEF, 0, 16'h4000);
        run_txn(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 16'h4000);
        // Odd byte write into a known word, then read back the merged word.
        run_txn(1'b1, 1'b0, 16'h3000, 16'h5A5A, 0, 16'h4000);
        run_txn(1'b1, 1'b1, 16'h3001, 16'h00A5, 0, 16'h4000);
        run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 16'h4000);
        // Even byte write and word write at an odd address.
        run_txn(1'b1, 1'b1, 16'h3002, 16'hFF3C, 0, 16'h4000);
        run_txn(1'b1, 1'b0, 16'h3003, 16'h1234, 0, 16'h4000);
        run_txn(1'b0, 1'b0, 16'h3002, 16'h0000, 0, 16'h4000);

        // Fill a small pool, then random traffic inside it.
        for (int i = 0; i < 32; i++)
            run_txn(1'b1, 1'b0, 16'(i * 2), 16'($urandom), 0, 16'($urandom));
        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)),
                    16'($urandom), 0, 16'($urandom));

        // Reset in cycle 3 of a write; read the word back afterwards.
        run_txn(1'b1, 1'b0, 16'h0004, 16'hC0DE, 3, 16'h4000);
        run_txn(1'b0, 1'b0, 16'h0004, 16'h0000, 0, 16'h4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
